// File: rtl/wb_retire_stage_pkg.sv
// rtl/wb_retire_stage_pkg.sv - shared types and defaults for the multi-lane write-back/retire stage
package wb_retire_stage_pkg;

  localparam int LANES_DEFAULT       = 2;
  localparam int TRACE_DEPTH_DEFAULT = 4;

  // One instruction slot as held in the WB stage register
  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [3:0]  strobe;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exc;
    logic [4:0]  exc_code;
  } WBLaneData;

  // One debug trace record, in retire order
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } TraceEntry;

  // Register-file write port image for one lane
  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } RFWrite;

  typedef RFWrite [LANES_DEFAULT-1:0] WBRetireToRFData;

  // Trace byte enable: writes to $0 and non-writing lanes are traced with no bytes enabled
  function automatic logic [3:0] trace_wen(input logic we, input logic [4:0] addr,
                                           input logic [3:0] strobe);
    return (we && (addr != 5'd0)) ? strobe : 4'h0;
  endfunction

endpackage

// File: rtl/wb_retire_stage_if.sv
// rtl/wb_retire_stage_if.sv - IO-to-WB bundle handshake interface
interface wb_retire_stage_if #(
  parameter int LANES = 2
);

  logic                   io_valid;
  logic [LANES-1:0]       io_lane_valid;
  logic [LANES-1:0][31:0] io_pc;
  logic [LANES-1:0]       io_we;
  logic [LANES-1:0][3:0]  io_strobe;
  logic [LANES-1:0][4:0]  io_addr;
  logic [LANES-1:0][31:0] io_data;
  logic [LANES-1:0]       io_exc;
  logic [LANES-1:0][4:0]  io_exc_code;
  logic                   wb_allow_in;

  modport master (
    output io_valid, io_lane_valid, io_pc, io_we, io_strobe, io_addr, io_data,
           io_exc, io_exc_code,
    input  wb_allow_in
  );

  modport slave (
    input  io_valid, io_lane_valid, io_pc, io_we, io_strobe, io_addr, io_data,
           io_exc, io_exc_code,
    output wb_allow_in
  );

endinterface

// File: rtl/wb_retire_stage_trace_fifo.sv
// rtl/wb_retire_stage_trace_fifo.sv - multi-push single-pop trace FIFO
module wb_retire_stage_trace_fifo
  import wb_retire_stage_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LANES-1:0]      i_push_valid,
  input  TraceEntry [LANES-1:0] i_push_data,
  output logic                  o_pop_valid,
  output TraceEntry             o_head,
  output logic [CW-1:0]         o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  TraceEntry               r_mem [DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [LANES-1:0][PW-1:0] w_wr_idx;
  int                      w_push_n;

  assign o_pop_valid = (r_count != '0);
  assign o_head      = r_mem[r_rd_ptr];
  assign o_count     = r_count;

  // Compact the pushing lanes into consecutive slots, lowest lane first
  always_comb begin
    w_push_n = 0;
    w_wr_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      w_wr_idx[i] = PW'((int'(r_wr_ptr) + w_push_n) % DEPTH);
      if (i_push_valid[i]) begin
        w_push_n = w_push_n + 1;
      end
    end
  end

  // Storage write; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (i_push_valid[i] && !reset) begin
        r_mem[w_wr_idx[i]] <= i_push_data[i];
      end
    end
  end

  // Pointer and occupancy bookkeeping; the head pops every cycle the FIFO is non-empty
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= PW'((int'(r_wr_ptr) + w_push_n) % DEPTH);
      if (o_pop_valid) begin
        r_rd_ptr <= PW'((int'(r_rd_ptr) + 1) % DEPTH);
      end
      r_count <= CW'(int'(r_count) + w_push_n - (o_pop_valid ? 1 : 0));
    end
  end

endmodule

// File: rtl/wb_retire_stage.sv
// rtl/wb_retire_stage.sv - multi-lane write-back/retire stage with exception kill and debug trace
module wb_retire_stage
  import wb_retire_stage_pkg::*;
#(
  parameter int LANES       = LANES_DEFAULT,
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  wb_retire_stage_if.slave       io,
  output logic [LANES-1:0]       rf_we,
  output logic [LANES-1:0][4:0]  rf_addr,
  output logic [LANES-1:0][3:0]  rf_strobe,
  output logic [LANES-1:0][31:0] rf_data,
  output logic                   exc_valid,
  output logic [31:0]            exc_pc,
  output logic [4:0]             exc_code,
  output logic [31:0]            debug_pc,
  output logic [3:0]             debug_wen,
  output logic [4:0]             debug_waddr,
  output logic [31:0]            debug_wdata
);

  localparam int CW = $clog2(TRACE_DEPTH + 1);

  if ((LANES < 1) || (TRACE_DEPTH < LANES)) begin : g_bad_params
    $error("wb_retire_stage: need LANES >= 1 and TRACE_DEPTH >= LANES");
  end

  logic                  r_wb_valid;
  logic [LANES-1:0]      r_lane_valid;
  WBLaneData [LANES-1:0] r_lane;

  logic [CW-1:0]         w_count;
  logic                  w_ready_go;
  logic                  w_allow_in;
  logic                  w_commit;
  logic                  w_exc_hit;
  logic                  w_exc_valid;
  logic [31:0]           w_exc_pc;
  logic [4:0]            w_exc_code;
  logic [LANES-1:0]      w_killed;
  logic [LANES-1:0]      w_push_valid;
  TraceEntry [LANES-1:0] w_push_data;
  logic                  w_pop;
  TraceEntry             w_head;

  // Registered count only: a same-cycle pop is not credited, so a full bundle always fits
  assign w_ready_go      = (TRACE_DEPTH - int'(w_count)) >= LANES;
  assign w_allow_in      = !r_wb_valid || w_ready_go;
  assign io.wb_allow_in  = w_allow_in;
  assign w_commit        = r_wb_valid && w_ready_go && !reset;
  assign w_exc_valid     = w_commit && w_exc_hit;
  assign exc_valid       = w_exc_valid;
  assign exc_pc          = w_exc_pc;
  assign exc_code        = w_exc_code;

  // Stage register; an exception commit flushes the stage and drops whatever IO offers alongside it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_valid   <= 1'b0;
      r_lane_valid <= '0;
      r_lane       <= '0;
    end else if (w_exc_valid) begin
      r_wb_valid <= 1'b0;
    end else if (w_allow_in) begin
      r_wb_valid <= io.io_valid;
      if (io.io_valid) begin
        r_lane_valid <= io.io_lane_valid;
        for (int i = 0; i < LANES; i++) begin
          r_lane[i].pc       <= io.io_pc[i];
          r_lane[i].we       <= io.io_we[i];
          r_lane[i].strobe   <= io.io_strobe[i];
          r_lane[i].addr     <= io.io_addr[i];
          r_lane[i].data     <= io.io_data[i];
          r_lane[i].exc      <= io.io_exc[i];
          r_lane[i].exc_code <= io.io_exc_code[i];
        end
      end
    end
  end

  // Lowest excepting lane selects the CP0 report and kills itself and every lane above it
  always_comb begin
    w_exc_hit  = 1'b0;
    w_exc_pc   = '0;
    w_exc_code = '0;
    w_killed   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!w_exc_hit && r_lane_valid[i] && r_lane[i].exc) begin
        w_exc_hit  = 1'b1;
        w_exc_pc   = r_lane[i].pc;
        w_exc_code = r_lane[i].exc_code;
      end
      w_killed[i] = w_exc_hit;
    end
  end

  // Per-lane RF writes and trace pushes for surviving lanes; $0 writes never reach the RF
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_push_valid[i]     = w_commit && r_lane_valid[i] && !w_killed[i];
      w_push_data[i].pc   = r_lane[i].pc;
      w_push_data[i].wen  = trace_wen(r_lane[i].we, r_lane[i].addr, r_lane[i].strobe);
      w_push_data[i].addr = r_lane[i].addr;
      w_push_data[i].data = r_lane[i].data;
      rf_we[i]            = w_push_valid[i] && r_lane[i].we && (r_lane[i].addr != 5'd0);
      rf_addr[i]          = r_lane[i].addr;
      rf_strobe[i]        = r_lane[i].strobe;
      rf_data[i]          = r_lane[i].data;
    end
  end

  wb_retire_stage_trace_fifo #(
    .LANES (LANES),
    .DEPTH (TRACE_DEPTH),
    .CW    (CW)
  ) u_trace_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_push_valid (w_push_valid),
    .i_push_data  (w_push_data),
    .o_pop_valid  (w_pop),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  // Debug trace port: load the FIFO head when one pops, otherwise hold with no bytes enabled
  always_ff @(posedge clock) begin
    if (reset) begin
      debug_pc    <= '0;
      debug_wen   <= '0;
      debug_waddr <= '0;
      debug_wdata <= '0;
    end else if (w_pop) begin
      debug_pc    <= w_head.pc;
      debug_wen   <= w_head.wen;
      debug_waddr <= w_head.addr;
      debug_wdata <= w_head.data;
    end else begin
      debug_wen <= 4'h0;
    end
  end

endmodule
